rhythm_judge: RTL and testbench



---
 rtl/rhythm_judge.sv | 195 +++++++++++++++++++
 tb/tb_rhythm_judge.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rhythm_judge.sv
`default_nettype none
// rhythm_judge: millisecond song clock, per-lane note FIFOs and a round-robin
// lane scanner that grades DFJK key presses and expires unhit notes.
module rhythm_judge #(
    parameter int TICK_DIV    = 50000,
    parameter int PERFECT_WIN = 30,
    parameter int GOOD_WIN    = 80,
    parameter int MISS_WIN    = 120,
    parameter int QDEPTH      = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        run,
    input  logic [3:0]  key_dfjk,
    input  logic        note_valid,
    input  logic [1:0]  note_lane,
    input  logic [15:0] note_time,
    output logic        note_ready,
    output logic [15:0] song_time,
    output logic        judge_valid,
    output logic [1:0]  judge_lane,
    output logic [1:0]  judge_result,
    output logic [15:0] score,
    output logic [9:0]  combo,
    output logic [9:0]  max_combo
);
    localparam int AW = $clog2(QDEPTH);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [1:0] C_PERFECT = 2'b11;
    localparam logic [1:0] C_GOOD    = 2'b10;
    localparam logic [1:0] C_MISS    = 2'b01;
    localparam logic signed [16:0] C_LATE = 17'(MISS_WIN);
    localparam logic [AW:0] C_PTR_ONE = (AW+1)'(1);

    logic [3:0]    sync1_q, sync2_q, sync3_q;
    logic          run_q, alive_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   song_q, song_d;
    logic [15:0]   mem_q [4][QDEPTH];
    logic [AW:0]   wp_q [4];
    logic [AW:0]   rp_q [4];
    logic [3:0]    pend_q, pend_d;
    logic [1:0]    slot_q;
    logic          jv_q, jv_d;
    logic [1:0]    jl_q, jr_q, jr_d;
    logic [15:0]   score_q, score_d;
    logic [9:0]    combo_q, combo_d, maxc_q, maxc_d;

    logic [3:0]         full_w, empty_w, key_rise;
    logic               clear, push, pop, pend_clr;
    logic [15:0]        head;
    logic signed [16:0] delta;
    logic [16:0]        absd;
    logic [16:0]        score_sum;

    always_comb begin
        for (int l = 0; l < 4; l++) begin
            empty_w[l] = (wp_q[l] == rp_q[l]);
            full_w[l]  = (wp_q[l][AW] != rp_q[l][AW]) &&
                         (wp_q[l][AW-1:0] == rp_q[l][AW-1:0]);
        end
    end

    assign key_rise   = sync2_q & ~sync3_q;
    assign clear      = run & ~run_q;
    assign note_ready = alive_q & ~clear & ~full_w[note_lane];
    assign push       = note_valid & note_ready;
    assign head       = mem_q[slot_q][rp_q[slot_q][AW-1:0]];
    assign delta      = $signed({1'b0, song_q}) - $signed({1'b0, head});
    assign absd       = delta[16] ? 17'(-delta) : 17'(delta);

    // Slot service: a pending press is graded against the lane head; an idle
    // lane only retires a head that has drifted past the late window.
    always_comb begin
        pop      = 1'b0;
        jv_d     = 1'b0;
        jr_d     = 2'b00;
        pend_clr = 1'b0;
        if (run && !clear) begin
            if (pend_q[slot_q]) begin
                if (empty_w[slot_q]) begin
                    pend_clr = 1'b1;
                end else if (delta > C_LATE) begin
                    // stale head expires; the press stays pending for the next note
                    pop = 1'b1; jv_d = 1'b1; jr_d = C_MISS;
                end else if (absd <= 17'(PERFECT_WIN)) begin
                    pop = 1'b1; jv_d = 1'b1; jr_d = C_PERFECT; pend_clr = 1'b1;
                end else if (absd <= 17'(GOOD_WIN)) begin
                    pop = 1'b1; jv_d = 1'b1; jr_d = C_GOOD; pend_clr = 1'b1;
                end else if (absd <= 17'(MISS_WIN)) begin
                    pop = 1'b1; jv_d = 1'b1; jr_d = C_MISS; pend_clr = 1'b1;
                end else begin
                    pend_clr = 1'b1;
                end
            end else if (!empty_w[slot_q] && delta > C_LATE) begin
                pop = 1'b1; jv_d = 1'b1; jr_d = C_MISS;
            end
        end
        pend_d = pend_q;
        if (pend_clr) pend_d[slot_q] = 1'b0;
        pend_d = pend_d | key_rise;
        if (clear) pend_d = '0;
    end

    always_comb begin
        presc_d = presc_q;
        song_d  = song_q;
        if (clear) begin
            presc_d = '0;
            song_d  = '0;
        end else if (run) begin
            if (presc_q == PW'(TICK_DIV - 1)) begin
                presc_d = '0;
                if (song_q != 16'hFFFF) song_d = song_q + 16'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_comb begin
        score_d   = score_q;
        combo_d   = combo_q;
        score_sum = {1'b0, score_q} + ((jr_d == C_PERFECT) ? 17'd3 : 17'd1);
        if (jv_d) begin
            if (jr_d == C_MISS) begin
                combo_d = '0;
            end else begin
                score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                combo_d = (combo_q == 10'd999) ? combo_q : combo_q + 10'd1;
            end
        end
        maxc_d = (combo_d > maxc_q) ? combo_d : maxc_q;
        if (clear) begin
            score_d = '0;
            combo_d = '0;
            maxc_d  = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q <= '0; sync2_q <= '0; sync3_q <= '0;
            run_q   <= 1'b0; alive_q <= 1'b0;
            presc_q <= '0; song_q <= '0;
            pend_q  <= '0; slot_q <= '0;
            jv_q    <= 1'b0; jl_q <= '0; jr_q <= '0;
            score_q <= '0; combo_q <= '0; maxc_q <= '0;
            for (int l = 0; l < 4; l++) begin
                wp_q[l] <= '0;
                rp_q[l] <= '0;
                for (int i = 0; i < QDEPTH; i++) mem_q[l][i] <= '0;
            end
        end else begin
            sync1_q <= key_dfjk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            run_q   <= run;
            alive_q <= 1'b1;
            presc_q <= presc_d;
            song_q  <= song_d;
            pend_q  <= pend_d;
            if (run) slot_q <= slot_q + 2'd1;
            jv_q    <= jv_d;
            if (jv_d) begin
                jl_q <= slot_q;
                jr_q <= jr_d;
            end
            score_q <= score_d;
            combo_q <= combo_d;
            maxc_q  <= maxc_d;
            if (clear) begin
                for (int l = 0; l < 4; l++) begin
                    wp_q[l] <= '0;
                    rp_q[l] <= '0;
                end
            end else begin
                if (push) begin
                    mem_q[note_lane][wp_q[note_lane][AW-1:0]] <= note_time;
                    wp_q[note_lane] <= wp_q[note_lane] + C_PTR_ONE;
                end
                if (pop) rp_q[slot_q] <= rp_q[slot_q] + C_PTR_ONE;
            end
        end
    end

    assign song_time    = song_q;
    assign judge_valid  = jv_q;
    assign judge_lane   = jl_q;
    assign judge_result = jr_q;
    assign score        = score_q;
    assign combo        = combo_q;
    assign max_combo    = maxc_q;
endmodule
`default_nettype wire

// File: tb/tb_rhythm_judge.sv
`default_nettype none
// tb_rhythm_judge: directed scenarios plus randomized note charts, with a
// per-lane expected-judgement scoreboard drained by an output monitor.
module tb_rhythm_judge;
    localparam int TD = 10;
    localparam int NR = 5;

    logic        clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        run = 1'b0;
    logic [3:0]  key = 4'd0;
    logic        note_valid = 1'b0;
    logic [1:0]  note_lane = 2'd0;
    logic [15:0] note_time = 16'd0;
    logic        note_ready, judge_valid;
    logic [15:0] song_time, score;
    logic [1:0]  judge_lane, judge_result;
    logic [9:0]  combo, max_combo;

    always #5 clk = ~clk;

    rhythm_judge #(.TICK_DIV(TD)) dut (
        .Clk(clk), .Reset_n(Reset_n), .run(run), .key_dfjk(key),
        .note_valid(note_valid), .note_lane(note_lane), .note_time(note_time),
        .note_ready(note_ready), .song_time(song_time),
        .judge_valid(judge_valid), .judge_lane(judge_lane), .judge_result(judge_result),
        .score(score), .combo(combo), .max_combo(max_combo)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [1:0] exp_q [4][$];
    int m_score = 0, m_combo = 0, m_max = 0;
    int m_time, m_pre;
    logic m_run_q;
    int r_t [4][NR];
    int r_off [4][NR];
    bit r_press [4][NR];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Spec-level grading of a press |offset| ticks away from the target.
    function automatic logic [1:0] grade(input int off);
        int a;
        a = (off < 0) ? -off : off;
        if (a <= 30) return 2'b11;
        if (a <= 80) return 2'b10;
        return 2'b01;
    endfunction

    // Song time = completed TICK_DIV periods of run since the last start.
    always @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_run_q <= 1'b0; m_pre <= 0; m_time <= 0;
        end else begin
            m_run_q <= run;
            if (run && !m_run_q) begin
                m_pre <= 0; m_time <= 0;
            end else if (run) begin
                if (m_pre == TD - 1) begin
                    m_pre <= 0;
                    if (m_time < 65535) m_time <= m_time + 1;
                end else begin
                    m_pre <= m_pre + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        int l;
        logic [1:0] e;
        if (Reset_n && judge_valid) begin
            l = int'(judge_lane);
            if (exp_q[l].size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_judge: lane %0d result %0d, expected no judgement", l, judge_result);
            end else begin
                e = exp_q[l].pop_front();
                check($sformatf("judge_result_lane%0d", l), int'(judge_result), int'(e));
                if (e == 2'b01) m_combo = 0;
                else begin
                    m_score = m_score + ((e == 2'b11) ? 3 : 1);
                    if (m_score > 65535) m_score = 65535;
                    if (m_combo < 999) m_combo++;
                end
                if (m_combo > m_max) m_max = m_combo;
                check("score", int'(score), m_score);
                check("combo", int'(combo), m_combo);
                check("max_combo", int'(max_combo), m_max);
                check("judge_song_time", int'(song_time), m_time);
            end
        end
    end

    task automatic wait_time(input int t);
        int n = 0;
        while (m_time < t) begin
            @(negedge clk);
            n++;
            if (n > 40000) begin
                n_cmp++; n_fail++;
                $display("FAIL wait_time: song time %0d, expected to reach %0d", m_time, t);
                return;
            end
        end
    endtask

    task automatic press(input int l);
        key[l] = 1'b1;
        repeat (3) @(negedge clk);
        key[l] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic push_note(input int l, input int t);
        int n = 0;
        note_lane = 2'(l); note_time = 16'(t); note_valid = 1'b1;
        #1;
        while (!note_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (!note_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL push_note: note_ready %0d on lane %0d, expected 1", note_ready, l);
        end
        @(posedge clk); #1;
        note_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_judge();
        int n = 0;
        while (!judge_valid && n < 2000) begin
            @(negedge clk); n++;
        end
        if (!judge_valid) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_judge: judge_valid 0, expected a pulse");
        end
    endtask

    task automatic start_song();
        @(negedge clk) run = 1'b0;
        @(negedge clk) run = 1'b1;
        m_score = 0; m_combo = 0; m_max = 0;
        #1 check("clear_note_ready", int'(note_ready), 0);
        @(negedge clk);
        check("clear_song_time", int'(song_time), 0);
        check("clear_score", int'(score), 0);
        check("clear_combo", int'(combo), 0);
        check("clear_max_combo", int'(max_combo), 0);
    endtask

    task automatic lane_proc(input int l);
        for (int i = 0; i < NR; i++) begin
            if (r_press[l][i]) begin
                wait_time(r_t[l][i] + r_off[l][i]);
                press(l);
            end
        end
    endtask

    initial begin
        int n, last;
        repeat (3) @(negedge clk);
        check("rst_judge_valid", int'(judge_valid), 0);
        check("rst_score", int'(score), 0);
        check("rst_combo", int'(combo), 0);
        check("rst_max_combo", int'(max_combo), 0);
        check("rst_song_time", int'(song_time), 0);
        check("rst_note_ready", int'(note_ready), 0);
        Reset_n = 1'b1;
        @(negedge clk);

        run = 1'b1;
        repeat (101) @(posedge clk);
        #1 check("timer_run", int'(song_time), 10);
        @(negedge clk) run = 1'b0;
        repeat (50) @(negedge clk);
        check("timer_hold", int'(song_time), 10);

        start_song();
        push_note(1, 20); push_note(2, 20); push_note(0, 5); push_note(3, 500);
        exp_q[1].push_back(2'b11); exp_q[2].push_back(2'b10); exp_q[0].push_back(2'b01);
        wait_time(20); press(1);
        wait_time(75); press(2);
        repeat (15) @(negedge clk);
        check("pg_score", int'(score), 4);
        check("pg_combo", int'(combo), 2);
        check("pg_max_combo", int'(max_combo), 2);
        wait_time(100); press(3);
        wait_time(110); press(2);
        wait_judge();
        check("expire_lane", int'(judge_lane), 0);
        check("expire_time", int'(song_time), 126);
        check("expire_combo", int'(combo), 0);
        check("expire_max_combo", int'(max_combo), 2);

        push_note(0, 150);
        for (int k = 0; k < 7; k++) push_note(0, 1000 + k);
        note_lane = 2'd0; #1 check("bp_full_lane0", int'(note_ready), 0);
        note_lane = 2'd1; #1 check("bp_lane1_open", int'(note_ready), 1);
        exp_q[0].push_back(2'b11);
        wait_time(150); press(0);
        repeat (10) @(negedge clk);
        note_lane = 2'd0; #1 check("bp_after_pop", int'(note_ready), 1);
        exp_q[3].push_back(2'b11);
        wait_time(500); press(3);
        repeat (15) @(negedge clk);

        start_song();
        for (int k = 1; k <= 3; k++) begin
            push_note(1, 30 * k);
            exp_q[1].push_back(2'b11);
        end
        for (int k = 1; k <= 3; k++) begin
            wait_time(30 * k); press(1);
        end
        repeat (15) @(negedge clk);
        check("pre_clear_score", int'(score), 9);
        check("pre_clear_combo", int'(combo), 3);
        start_song();
        for (int l = 0; l < 4; l++) begin
            note_lane = 2'(l); #1 check($sformatf("post_clear_ready%0d", l), int'(note_ready), 1);
        end
        press(1);
        repeat (15) @(negedge clk);

        push_note(2, 20);
        wait_time(20);
        key[2] = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!judge_valid && n < 50);
        if (!judge_valid) begin
            n_cmp++; n_fail++;
            $display("FAIL reset_pulse: judge_valid 0, expected a pulse");
        end
        Reset_n = 1'b0;
        #1 check("reset_drops_valid", int'(judge_valid), 0);
        check("reset_song_time", int'(song_time), 0);
        key[2] = 1'b0; run = 1'b0;
        repeat (3) @(negedge clk);
        Reset_n = 1'b1;
        @(negedge clk);

        start_song();
        last = 0;
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < NR; i++) begin
                int off;
                r_t[l][i] = 250 + i * 300 + $urandom_range(0, 40);
                r_press[l][i] = ($urandom_range(0, 3) != 0);
                do off = $urandom_range(0, 240) - 120;
                while (off == -81 || off == -31 || off == 30 || off == 80 || off == 120);
                r_off[l][i] = off;
                if (r_t[l][i] > last) last = r_t[l][i];
            end
        end
        for (int i = 0; i < NR; i++) begin
            for (int l = 0; l < 4; l++) begin
                push_note(l, r_t[l][i]);
                exp_q[l].push_back(r_press[l][i] ? grade(r_off[l][i]) : 2'b01);
            end
        end
        for (int l = 0; l < 4; l++) begin
            automatic int ll = l;
            fork
                lane_proc(ll);
            join_none
        end
        wait fork;
        wait_time(last + 130);
        repeat (10) @(negedge clk);
        for (int l = 0; l < 4; l++)
            check($sformatf("leftover_lane%0d", l), exp_q[l].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
